// File: rtl/multiplier_binary.sv
// Sequential shift-and-add unsigned multiplier with a Start/Ready handshake.
// One add or one shift per clock; a run takes 2*dp_width clocks.
module multiplier_binary #(
    parameter int unsigned dp_width = 5
) (
    input  logic                    Start,
    input  logic                    reset_b,
    input  logic                    clock,
    input  logic [dp_width-1:0]     Multiplicand,
    input  logic [dp_width-1:0]     Multiplier,
    output logic [2*dp_width-1:0]   Product,
    output logic                    Ready
);

    localparam int unsigned CW = $clog2(dp_width + 1);

    typedef enum logic [1:0] {
        S_idle  = 2'b00,
        S_add   = 2'b01,
        S_shift = 2'b10
    } state_t;

    state_t state, next_state;

    logic [dp_width-1:0] B;
    logic [dp_width-1:0] A;
    logic [dp_width-1:0] Q;
    logic                C;
    logic [CW-1:0]       P;

    // State register
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_idle;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the unused encoding falls back to idle
    always_comb begin
        next_state = S_idle;
        case (state)
            S_idle:  next_state = Start ? S_add : S_idle;
            S_add:   next_state = S_shift;
            S_shift: next_state = (P == CW'(0)) ? S_idle : S_add;
            default: next_state = S_idle;
        endcase
    end

    // Datapath: operand capture, conditional add, and the combined {C,A,Q} shift
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            B <= '0;
            A <= '0;
            Q <= '0;
            C <= 1'b0;
            P <= '0;
        end else begin
            case (state)
                S_idle: begin
                    if (Start) begin
                        B <= Multiplicand;
                        Q <= Multiplier;
                        A <= '0;
                        C <= 1'b0;
                        P <= CW'(dp_width);
                    end
                end
                S_add: begin
                    P <= P - CW'(1);
                    if (Q[0]) begin
                        {C, A} <= {1'b0, A} + {1'b0, B};
                    end
                end
                S_shift: begin
                    {C, A, Q} <= {1'b0, C, A, Q[dp_width-1:1]};
                end
                default: begin
                end
            endcase
        end
    end

    assign Product = {A, Q};
    assign Ready   = (state == S_idle);

endmodule

// File: tb/tb_multiplier_binary.sv
// Randomized scoreboard bench for multiplier_binary: expected products are queued
// at issue time and checked by a monitor whenever Ready rises after a run.
module tb_multiplier_binary;

    localparam int unsigned W  = 5;
    localparam int unsigned PW = 2 * W;

    logic          clock = 1'b0;
    logic          reset_b;
    logic          Start;
    logic [W-1:0]  Multiplicand;
    logic [W-1:0]  Multiplier;
    logic [PW-1:0] Product;
    logic          Ready;

    int            total = 0;
    int            bad = 0;
    logic [PW-1:0] sb[$];
    logic [PW-1:0] last_prod = '0;
    logic          prev_ready = 1'b1;
    int            low_cnt = 0;

    multiplier_binary #(.dp_width(W)) dut (
        .Start        (Start),
        .reset_b      (reset_b),
        .clock        (clock),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Ready        (Ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns at a falling edge with Ready high, or flags a timeout
    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!Ready && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!Ready) begin
            total++;
            bad++;
            $display("FAIL wait_ready: Ready still low after %0d cycles", n);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] b, input logic [W-1:0] q);
        int unsigned eb = b;
        int unsigned eq = q;
        return PW'(eb * eq);
    endfunction

    task automatic issue(input logic [W-1:0] b, input logic [W-1:0] q);
        wait_ready();
        Start        = 1'b1;
        Multiplicand = b;
        Multiplier   = q;
        sb.push_back(model(b, q));
        @(posedge clock);
        #1;
        Start        = 1'b0;
        Multiplicand = W'($urandom);
        Multiplier   = W'($urandom);
    endtask

    task automatic junk_start();
        Start        = 1'b1;
        Multiplicand = W'($urandom);
        Multiplier   = W'($urandom);
        @(posedge clock);
        #1;
        Start = 1'b0;
    endtask

    // Monitor: on each Ready rise, check busy length and the oldest queued product
    always @(negedge clock) begin
        if (!reset_b) begin
            prev_ready = 1'b1;
            low_cnt    = 0;
        end else begin
            if (!Ready) low_cnt++;
            if (Ready && !prev_ready) begin
                check("latency", 32'(low_cnt), 32'(PW));
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0d with empty scoreboard", Product);
                end else begin
                    last_prod = sb.pop_front();
                    check("product", 32'(Product), 32'(last_prod));
                end
            end
            if (Ready) low_cnt = 0;
            prev_ready = Ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_b      = 1'b0;
        Start        = 1'b0;
        Multiplicand = '0;
        Multiplier   = '0;
        #12;
        check("reset_ready", 32'(Ready), 32'd1);
        check("reset_product", 32'(Product), 32'd0);
        @(negedge clock);
        #2 reset_b = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_ready", 32'(Ready), 32'd1);
        check("idle_product", 32'(Product), 32'd0);

        issue(5'b10111, 5'b10011);
        issue(5'b11111, 5'b11111);
        issue(5'b00000, 5'b10101);
        issue(5'b10101, 5'b00000);

        // A Start pulse mid-run must not disturb the run in flight
        issue(5'b10111, 5'b10011);
        repeat (3) @(posedge clock);
        #1 junk_start();

        // Start held high across a completion: back-to-back runs
        wait_ready();
        Start        = 1'b1;
        Multiplicand = 5'd7;
        Multiplier   = 5'd9;
        sb.push_back(model(5'd7, 5'd9));
        @(posedge clock);
        #1;
        Multiplicand = W'($urandom);
        Multiplier   = W'($urandom);
        wait_ready();
        Multiplicand = 5'd12;
        Multiplier   = 5'd13;
        sb.push_back(model(5'd12, 5'd13));
        @(posedge clock);
        #1 Start = 1'b0;

        // Reset mid-run aborts immediately
        wait_ready();
        Start        = 1'b1;
        Multiplicand = 5'b10111;
        Multiplier   = 5'b10011;
        @(posedge clock);
        #1 Start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_b = 1'b0;
        sb.delete();
        #1;
        check("abort_ready", 32'(Ready), 32'd1);
        check("abort_product", 32'(Product), 32'd0);
        @(negedge clock);
        #2 reset_b = 1'b1;
        issue(5'b00011, 5'b00101);

        for (int i = 0; i < 25; i++) begin
            issue(W'($urandom), W'($urandom));
            if ($urandom_range(1) == 1) begin
                repeat ($urandom_range(6, 1)) @(posedge clock);
                #1 junk_start();
            end
        end

        wait_ready();
        repeat (3) @(negedge clock);
        check("idle_hold", 32'(Product), 32'(last_prod));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
